partition_sweep_checker: RTL and testbench

- Synthesizable exhaustive-sweep harness for combinational partitions in approximate-logic-synthesis flows.
- Drives every PI pattern 0 to 2^PI_W-1 into an exact partition and an approximate partition, sampled side by side.
- Accumulates error metrics in hardware: error count, Hamming sum, absolute-error sum, max error and first failing pattern.
- Generalises the fixed 7-in/4-out print-only sweep to any width, with configurable settle time, signed mode and abort.

---
 rtl/partition_sweep_pkg.sv | 23 ++
 rtl/po_error_metric.sv | 40 ++++
 rtl/partition_sweep_checker.sv | 174 +++++++++++++++++
 tb/tb_partition_sweep_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/partition_sweep_pkg.sv
// Shared state encoding and metric-width helpers for partition sweep checkers.
package partition_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t FINISH = 2'd2;

  // Bits needed to count mismatching output bits of one pattern.
  function automatic int hd_w(input int po_w);
    return $clog2(po_w + 1);
  endfunction

  function automatic int hd_sum_w(input int pi_w, input int po_w);
    return pi_w + $clog2(po_w + 1);
  endfunction

  function automatic int abs_sum_w(input int pi_w, input int po_w);
    return pi_w + po_w;
  endfunction

endpackage

// File: rtl/po_error_metric.sv
// Combinational per-pattern error metrics between an exact and an approximate
// partition output: mismatch flag, Hamming distance and absolute error.
module po_error_metric
  import partition_sweep_pkg::*;
#(
  parameter int PO_W = 4
) (
  input  logic [PO_W-1:0]     exact,
  input  logic [PO_W-1:0]     approx,
  input  logic                signed_mode,
  output logic                mismatch,
  output logic [hd_w(PO_W)-1:0] hd,
  output logic [PO_W-1:0]     abs_err
);

  localparam int HD_W = hd_w(PO_W);

  logic [PO_W-1:0] diff_bits;
  logic [PO_W:0]   ext_exact;
  logic [PO_W:0]   ext_approx;
  logic [PO_W:0]   diff;

  assign diff_bits  = exact ^ approx;
  assign mismatch   = |diff_bits;
  assign ext_exact  = {signed_mode & exact[PO_W-1], exact};
  assign ext_approx = {signed_mode & approx[PO_W-1], approx};
  assign diff       = ext_exact - ext_approx;

  // |diff| never exceeds 2^PO_W-1 in either mode, so dropping the top bit is the clamp.
  assign abs_err = diff[PO_W] ? PO_W'(-diff) : diff[PO_W-1:0];

  // NOTE: give every always_comb output a default before the loop so no latch is inferred.
  always_comb begin
    hd = '0;
    for (int i = 0; i < PO_W; i++) begin
      hd = hd + HD_W'(diff_bits[i]);
    end
  end

endmodule

// File: rtl/partition_sweep_checker.sv
// Exhaustive PI sweep over an exact and an approximate partition, accumulating
// mismatch count, Hamming sum, absolute-error sum, max error and first failure.
module partition_sweep_checker
  import partition_sweep_pkg::*;
#(
  parameter int PI_W   = 7,
  parameter int PO_W   = 4,
  parameter int SETTLE = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             signed_mode,
  output logic [PI_W-1:0]                  pi_o,
  input  logic [PO_W-1:0]                  exact_po_i,
  input  logic [PO_W-1:0]                  approx_po_i,
  output logic                             busy,
  output logic                             done,
  output logic                             result_valid,
  output logic [PI_W:0]                    err_count,
  output logic [hd_sum_w(PI_W, PO_W)-1:0]  hd_sum,
  output logic [abs_sum_w(PI_W, PO_W)-1:0] abs_err_sum,
  output logic [PO_W-1:0]                  max_abs_err,
  output logic [PI_W-1:0]                  first_err_pi,
  output logic                             first_err_valid
);

  localparam int HD_W = hd_w(PO_W);
  localparam int HS_W = hd_sum_w(PI_W, PO_W);
  localparam int AS_W = abs_sum_w(PI_W, PO_W);
  localparam int EC_W = PI_W + 1;

  localparam logic [PI_W-1:0] PI_LAST   = '1;
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

  state_t          state_q, state_d;
  logic [PI_W-1:0] pi_q, pi_d;
  logic [3:0]      settle_q, settle_d;
  logic            signed_q, signed_d;
  logic [EC_W-1:0] err_count_q, err_count_d;
  logic [HS_W-1:0] hd_sum_q, hd_sum_d;
  logic [AS_W-1:0] abs_sum_q, abs_sum_d;
  logic [PO_W-1:0] max_err_q, max_err_d;
  logic [PI_W-1:0] first_pi_q, first_pi_d;
  logic            first_vld_q, first_vld_d;
  logic            done_q, done_d;
  logic            rv_q, rv_d;

  logic            mismatch;
  logic [HD_W-1:0] hd;
  logic [PO_W-1:0] abs_err;

  po_error_metric #(.PO_W(PO_W)) u_metric (
    .exact       (exact_po_i),
    .approx      (approx_po_i),
    .signed_mode (signed_q),
    .mismatch    (mismatch),
    .hd          (hd),
    .abs_err     (abs_err)
  );

  always_comb begin
    state_d     = state_q;
    pi_d        = pi_q;
    settle_d    = settle_q;
    signed_d    = signed_q;
    err_count_d = err_count_q;
    hd_sum_d    = hd_sum_q;
    abs_sum_d   = abs_sum_q;
    max_err_d   = max_err_q;
    first_pi_d  = first_pi_q;
    first_vld_d = first_vld_q;
    done_d      = 1'b0;
    rv_d        = rv_q;

    case (state_q)
      IDLE: begin
        // abort has priority over a simultaneous start.
        if (start && !abort) begin
          state_d     = RUN;
          pi_d        = '0;
          settle_d    = SETTLE_LD;
          signed_d    = signed_mode;
          err_count_d = '0;
          hd_sum_d    = '0;
          abs_sum_d   = '0;
          max_err_d   = '0;
          first_pi_d  = '0;
          first_vld_d = 1'b0;
          rv_d        = 1'b0;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (settle_q == 4'd0) begin
          hd_sum_d  = hd_sum_q + HS_W'(hd);
          abs_sum_d = abs_sum_q + AS_W'(abs_err);
          if (abs_err > max_err_q) begin
            max_err_d = abs_err;
          end
          if (mismatch) begin
            err_count_d = err_count_q + EC_W'(1);
            if (!first_vld_q) begin
              first_pi_d  = pi_q;
              first_vld_d = 1'b1;
            end
          end
          settle_d = SETTLE_LD;
          if (pi_q == PI_LAST) begin
            state_d = FINISH;
          end else begin
            pi_d = pi_q + PI_W'(1);
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        rv_d    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pi_q        <= '0;
      settle_q    <= '0;
      signed_q    <= 1'b0;
      err_count_q <= '0;
      hd_sum_q    <= '0;
      abs_sum_q   <= '0;
      max_err_q   <= '0;
      first_pi_q  <= '0;
      first_vld_q <= 1'b0;
      done_q      <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pi_q        <= pi_d;
      settle_q    <= settle_d;
      signed_q    <= signed_d;
      err_count_q <= err_count_d;
      hd_sum_q    <= hd_sum_d;
      abs_sum_q   <= abs_sum_d;
      max_err_q   <= max_err_d;
      first_pi_q  <= first_pi_d;
      first_vld_q <= first_vld_d;
      done_q      <= done_d;
      rv_q        <= rv_d;
    end
  end

  assign pi_o            = pi_q;
  assign busy            = (state_q == RUN);
  assign done            = done_q;
  assign result_valid    = rv_q;
  assign err_count       = err_count_q;
  assign hd_sum          = hd_sum_q;
  assign abs_err_sum     = abs_sum_q;
  assign max_abs_err     = max_err_q;
  assign first_err_pi    = first_pi_q;
  assign first_err_valid = first_vld_q;

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Directed bench: two checker instances (SETTLE=0 and SETTLE=2) fed by
// tb-side partition models, with hand-computed sweep results.
module tb_partition_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start2 = 1'b0;
  logic abort = 1'b0;
  logic sm = 1'b0;
  int   mode = 0;
  bit   sel = 1'b0;

  int total = 0;
  int bad = 0;
  int pisamp[7];

  logic [6:0]  pi0, pi2, fe0, fe2;
  logic [3:0]  ex0, ap0, ex2, ap2, max0, max2;
  logic        busy0, busy2, done0, done2, rv0, rv2, fev0, fev2;
  logic [7:0]  ec0, ec2;
  logic [9:0]  hd0, hd2;
  logic [10:0] abs0, abs2;

  logic [6:0]  o_pi, o_fe;
  logic [3:0]  o_max;
  logic        o_busy, o_done, o_rv, o_fev;
  logic [7:0]  o_ec;
  logic [9:0]  o_hd;
  logic [10:0] o_abs;

  always #5 clk = ~clk;

  function automatic logic [3:0] f_exact(input int m, input logic [6:0] p);
    if (m == 2) return 4'b0111;
    return p[3:0];
  endfunction

  function automatic logic [3:0] f_approx(input int m, input logic [6:0] p);
    case (m)
      1:       return 4'b0000;
      2:       return 4'b1000;
      3:       return p[3:0] ^ 4'b0001;
      default: return p[3:0];
    endcase
  endfunction

  always_comb begin
    ex0 = f_exact(mode, pi0);
    ap0 = f_approx(mode, pi0);
    ex2 = f_exact(mode, pi2);
    ap2 = f_approx(mode, pi2);
  end

  always_comb begin
    o_pi   = sel ? pi2   : pi0;
    o_busy = sel ? busy2 : busy0;
    o_done = sel ? done2 : done0;
    o_rv   = sel ? rv2   : rv0;
    o_ec   = sel ? ec2   : ec0;
    o_hd   = sel ? hd2   : hd0;
    o_abs  = sel ? abs2  : abs0;
    o_max  = sel ? max2  : max0;
    o_fe   = sel ? fe2   : fe0;
    o_fev  = sel ? fev2  : fev0;
  end

  partition_sweep_checker #(.PI_W(7), .PO_W(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .signed_mode(sm),
    .pi_o(pi0), .exact_po_i(ex0), .approx_po_i(ap0),
    .busy(busy0), .done(done0), .result_valid(rv0),
    .err_count(ec0), .hd_sum(hd0), .abs_err_sum(abs0), .max_abs_err(max0),
    .first_err_pi(fe0), .first_err_valid(fev0)
  );

  partition_sweep_checker #(.PI_W(7), .PO_W(4), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .signed_mode(sm),
    .pi_o(pi2), .exact_po_i(ex2), .approx_po_i(ap2),
    .busy(busy2), .done(done2), .result_valid(rv2),
    .err_count(ec2), .hd_sum(hd2), .abs_err_sum(abs2), .max_abs_err(max2),
    .first_err_pi(fe2), .first_err_valid(fev2)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a sweep on the selected instance and returns at the negedge where done is seen.
  task automatic sweep(input bit s, input bit smode, output int lat);
    sel = s;
    @(negedge clk);
    sm = smode;
    if (s) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    check("busy_after_accept", o_busy, 1);
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i < 7) pisamp[i] = int'(o_pi);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (o_done) break;
    end
    if (!o_done) check("done_timeout", 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pi"},   pi0,   0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_rv"},   rv0,   0);
    check({tag, "_ec"},   ec0,   0);
    check({tag, "_hd"},   hd0,   0);
    check({tag, "_abs"},  abs0,  0);
    check({tag, "_max"},  max0,  0);
    check({tag, "_fe"},   fe0,   0);
    check({tag, "_fev"},  fev0,  0);
  endtask

  initial begin
    int lat;
    int n_done;
    int n_busy;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");

    // Identical partitions: clean sweep, latency 2^7*1+1.
    mode = 0;
    sweep(0, 0, lat);
    check("m0_latency", lat, 129);
    check("m0_done", o_done, 1);
    check("m0_rv", o_rv, 1);
    check("m0_busy", o_busy, 0);
    check("m0_ec", o_ec, 0);
    check("m0_hd", o_hd, 0);
    check("m0_abs", o_abs, 0);
    check("m0_fev", o_fev, 0);
    @(negedge clk);
    check("m0_done_one_cycle", o_done, 0);

    // approx stuck at zero.
    mode = 1;
    sweep(0, 0, lat);
    check("m1_ec", o_ec, 120);
    check("m1_hd", o_hd, 256);
    check("m1_abs", o_abs, 960);
    check("m1_max", o_max, 15);
    check("m1_fe", o_fe, 1);
    check("m1_fev", o_fev, 1);

    // 0111 vs 1000, unsigned then signed.
    mode = 2;
    sweep(0, 0, lat);
    check("m2u_max", o_max, 1);
    check("m2u_abs", o_abs, 128);
    check("m2u_hd", o_hd, 512);
    check("m2u_ec", o_ec, 128);
    check("m2u_fe", o_fe, 0);
    sweep(0, 1, lat);
    check("m2s_max", o_max, 15);
    check("m2s_abs", o_abs, 1920);
    check("m2s_hd", o_hd, 512);

    // SETTLE=2, LSB flipped.
    mode = 3;
    sweep(1, 0, lat);
    check("s2_latency", lat, 385);
    check("s2_pi0", pisamp[0], 0);
    check("s2_pi2", pisamp[2], 0);
    check("s2_pi3", pisamp[3], 1);
    check("s2_pi6", pisamp[6], 2);
    check("s2_ec", o_ec, 128);
    check("s2_hd", o_hd, 128);
    check("s2_max", o_max, 1);
    check("s2_abs", o_abs, 128);
    check("s2_rv", o_rv, 1);

    // Abort 10 cycles into RUN.
    sel = 0;
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", busy0, 1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_rv", rv0, 0);
    n_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_rv_later", rv0, 0);

    // start and abort together in IDLE: start ignored.
    @(negedge clk);
    start0 = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    abort = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy0) n_busy++;
      @(negedge clk);
    end
    check("start_abort_ignored", n_busy, 0);

    mode = 0;
    sweep(0, 0, lat);
    check("post_abort_latency", lat, 129);
    check("post_abort_rv", o_rv, 1);
    check("post_abort_ec", o_ec, 0);

    // Reset mid-sweep at pi_o=40.
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pi0 == 7'd40) break;
      @(negedge clk);
    end
    check("reach_pi40", pi0, 40);
    check("pi40_ec_nonzero", ec0 != 0, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("midrst");

    sweep(0, 0, lat);
    check("restart_pi0", pisamp[0], 0);
    check("restart_latency", lat, 129);
    check("restart_ec", o_ec, 120);
    check("restart_hd", o_hd, 256);
    check("restart_abs", o_abs, 960);
    check("restart_fe", o_fe, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
